// File: rtl/tick_serializer.sv
// tick_serializer
//   Samples the clock divider's div_clk level in the clk domain and turns each
//   rising edge into a one-cycle tick. A word taken through a valid/ready
//   handshake is shifted out on sdo, one bit per tick period. frame marks the
//   bit window and done pulses once when the frame finishes.
//
// Parameters
//   DATA_W     word width in bits (>= 2)
//   MSB_FIRST  1: din[DATA_W-1] goes out first; 0: din[0] goes out first
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   div_clk    divided clock level, already synchronous to clk
//   din        word to transmit, sampled on acceptance
//   din_valid  din is valid
//   din_ready  block can accept a word (combinational, high in IDLE)
//   sdo        serial data (registered)
//   frame      high while a bit is driven on sdo (registered)
//   done       one-cycle pulse at the end of a frame (registered)
module tick_serializer #(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_clk,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sdo,
  output logic              frame,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            state;
  logic              div_q;
  logic              tick;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic              head_bit;
  logic [CNT_W-1:0]  cnt;

  // div_q resets high so a div_clk already high at reset release is not
  // mistaken for a rising edge.
  assign tick      = div_clk & ~div_q;
  assign din_ready = (state == IDLE);

  // The bit to send next always sits at the head of the shift register.
  generate
    if (MSB_FIRST) begin : g_msb
      assign head_bit   = shreg[DATA_W-1];
      assign shreg_next = {shreg[DATA_W-2:0], 1'b0};
    end else begin : g_lsb
      assign head_bit   = shreg[0];
      assign shreg_next = {1'b0, shreg[DATA_W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      div_q <= 1'b1;
      shreg <= '0;
      cnt   <= '0;
      sdo   <= 1'b0;
      frame <= 1'b0;
      done  <= 1'b0;
    end else begin
      div_q <= div_clk;
      done  <= 1'b0;
      unique case (state)
        // A tick coinciding with acceptance is deliberately ignored: the
        // first bit waits for the next div_clk rising edge.
        IDLE: begin
          if (din_valid) begin
            shreg <= din;
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (tick) begin
            sdo   <= head_bit;
            shreg <= shreg_next;
            frame <= 1'b1;
            cnt   <= CNT_ONE;
            state <= SHIFT;
          end
        end
        // cnt is the number of bits already driven; the tick after the last
        // bit closes the frame.
        SHIFT: begin
          if (tick) begin
            if (cnt < CNT_LAST) begin
              sdo   <= head_bit;
              shreg <= shreg_next;
              cnt   <= cnt + CNT_ONE;
            end else begin
              sdo   <= 1'b0;
              frame <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_serializer.sv
// Bench for tick_serializer with DATA_W=8. Two instances share all inputs,
// one MSB-first and one LSB-first. A reference model tracks each frame as
// "word plus number of ticks seen" and predicts every output every cycle.
module tb_tick_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         div_clk = 1'b0;
  logic [W-1:0] din;
  logic         din_valid;
  logic         rdy_m, sdo_m, frame_m, done_m;
  logic         rdy_l, sdo_l, frame_l, done_l;

  int   div_half = 8;
  logic div_run  = 1'b0;
  int   div_cnt  = 0;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  tick_serializer #(.DATA_W(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .div_clk(div_clk), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .sdo(sdo_m), .frame(frame_m), .done(done_m)
  );

  tick_serializer #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .div_clk(div_clk), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .sdo(sdo_l), .frame(frame_l), .done(done_l)
  );

  // divided clock: toggles every div_half clk cycles while running
  always @(negedge clk) begin
    if (div_run) begin
      if (div_cnt + 1 >= div_half) begin
        div_clk <= ~div_clk;
        div_cnt <= 0;
      end else begin
        div_cnt <= div_cnt + 1;
      end
    end
  end

  // reference model: busy holds a word; ticks counts div_clk rises since
  // acceptance. Ticks 1..W drive bit number ticks-1 of the send order,
  // tick W+1 ends the frame with done.
  logic         m_busy, m_prev, m_sdo_m, m_sdo_l, m_frame, m_done;
  logic [W-1:0] m_word;
  logic [3:0]   m_ticks;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  <= 1'b0;
      m_prev  <= 1'b1;
      m_word  <= '0;
      m_ticks <= '0;
      m_sdo_m <= 1'b0;
      m_sdo_l <= 1'b0;
      m_frame <= 1'b0;
      m_done  <= 1'b0;
    end else begin
      m_prev <= div_clk;
      m_done <= 1'b0;
      if (!m_busy) begin
        if (din_valid) begin
          m_word  <= din;
          m_busy  <= 1'b1;
          m_ticks <= '0;
        end
      end else if (div_clk && !m_prev) begin
        m_ticks <= m_ticks + 4'd1;
        if (m_ticks < 4'd8) begin
          m_frame <= 1'b1;
          m_sdo_m <= m_word[3'(4'd7 - m_ticks)];
          m_sdo_l <= m_word[m_ticks[2:0]];
        end else begin
          m_frame <= 1'b0;
          m_sdo_m <= 1'b0;
          m_sdo_l <= 1'b0;
          m_done  <= 1'b1;
          m_busy  <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one clk cycle: compare both DUTs against the model at the falling edge,
  // then leave 1 time unit before the caller drives inputs
  task automatic step();
    @(negedge clk);
    check("ready_m", rdy_m,   !m_busy);
    check("ready_l", rdy_l,   !m_busy);
    check("sdo_m",   sdo_m,   m_sdo_m);
    check("sdo_l",   sdo_l,   m_sdo_l);
    check("frame_m", frame_m, m_frame);
    check("frame_l", frame_l, m_frame);
    check("done_m",  done_m,  m_done);
    check("done_l",  done_l,  m_done);
    if (done_m) done_seen++;
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    int n;
    din = w;
    din_valid = 1'b1;
    n = 0;
    while (!rdy_m && n < 400) begin
      step();
      n++;
    end
    step();
    din_valid = 1'b0;
    check("accept_ready_low", rdy_m, 1'b0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done_m && n < budget) begin
      step();
      n++;
    end
    if (!done_m) check(name, 1'b0, 1'b1);
  endtask

  // records one full frame (16-clk tick period) and checks the literal
  // send order; pat[7] is the first bit on the wire
  task automatic record_frame(input string tag, input logic [7:0] pat_m,
                              input logic [7:0] pat_l);
    logic sm [512];
    logic sl [512];
    int   nf, n, d0;
    nf = 0;
    n  = 0;
    d0 = done_seen;
    while (!done_m && n < 600) begin
      step();
      if (frame_m && nf < 512) begin
        sm[nf] = sdo_m;
        sl[nf] = sdo_l;
        nf++;
      end
      n++;
    end
    repeat (20) step();
    check(tag, sdo_m, 1'b0);
    check_int({tag, "_frame_len"}, nf, 128);
    check_int({tag, "_done_count"}, done_seen - d0, 1);
    if (nf == 128) begin
      for (int k = 0; k < 8; k++) begin
        check({tag, "_msb_bit_start"}, sm[16*k],      pat_m[3'(7 - k)]);
        check({tag, "_msb_bit_end"},   sm[16*k + 15], pat_m[3'(7 - k)]);
        check({tag, "_lsb_bit_start"}, sl[16*k],      pat_l[3'(7 - k)]);
      end
    end
  endtask

  initial begin
    int n, d0;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    #2 rst = 1'b0;
    repeat (3) step();
    check("rst_ready", rdy_m, 1'b1);
    check("rst_sdo",   sdo_m, 1'b0);
    check("rst_frame", frame_m, 1'b0);
    check("rst_done",  done_m, 1'b0);
    rst = 1'b1;
    step();
    div_half = 8;
    div_run  = 1'b1;

    // A5 at 16-clk tick period, then 01
    send(8'hA5);
    record_frame("a5", 8'b10100101, 8'b10100101);
    send(8'h01);
    record_frame("x01", 8'b00000001, 8'b10000000);

    // back-to-back: valid held, 3C accepted in the done cycle of A5
    din = 8'hA5;
    din_valid = 1'b1;
    n = 0;
    while (rdy_m && n < 40) begin
      step();
      n++;
    end
    din = 8'h3C;
    wait_done("b2b_first_done_timeout", 400);
    check("b2b_ready_in_done", rdy_m, 1'b1);
    step();
    check("b2b_second_accepted", rdy_m, 1'b0);
    din_valid = 1'b0;
    n = 0;
    while (!frame_m && n < 40) begin
      step();
      n++;
    end
    check("b2b_no_gap_frame", frame_m, 1'b1);
    check("b2b_first_bit_m", sdo_m, 1'b0);
    check("b2b_first_bit_l", sdo_l, 1'b0);
    wait_done("b2b_second_done_timeout", 400);
    repeat (5) step();

    // din_valid with FF in SHIFT is ignored
    d0 = done_seen;
    send(8'hA5);
    repeat (60) step();
    din = 8'hFF;
    din_valid = 1'b1;
    step();
    check("busy_ignore_ready", rdy_m, 1'b0);
    din_valid = 1'b0;
    wait_done("busy_done_timeout", 400);
    step();
    check("busy_idle_after", rdy_m, 1'b1);
    check_int("busy_done_count", done_seen - d0, 1);

    // reset after 3 ticks of a frame
    send(8'hA5);
    n = 0;
    while (!frame_m && n < 40) begin
      step();
      n++;
    end
    repeat (36) step();
    d0 = done_seen;
    rst = 1'b0;
    #1;
    check("midrst_sdo",   sdo_m,   1'b0);
    check("midrst_frame", frame_m, 1'b0);
    check("midrst_done",  done_m,  1'b0);
    check("midrst_ready", rdy_m,   1'b1);
    check("midrst_sdo_l", sdo_l,   1'b0);
    n = 0;
    while (!div_clk && n < 40) begin
      step();
      n++;
    end
    div_run = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    send(8'h81);
    repeat (30) step();
    check("hold_no_frame", frame_m, 1'b0);
    div_run = 1'b1;
    n = 0;
    while (div_clk && n < 40) begin
      step();
      n++;
    end
    while (!div_clk && n < 80) begin
      step();
      n++;
    end
    check("relrst_pre_edge_frame", frame_m, 1'b0);
    step();
    check("relrst_post_edge_frame", frame_m, 1'b1);
    check("relrst_first_bit_m", sdo_m, 1'b1);
    check("relrst_first_bit_l", sdo_l, 1'b1);
    wait_done("relrst_done_timeout", 400);
    step();
    check_int("midrst_single_done", done_seen - d0, 1);

    // randomized traffic, tick periods 4..12 clk, pauses and rare resets
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) div_half = int'($urandom_range(2, 6));
      if ($urandom_range(0, 199) == 0) begin
        div_run = 1'b0;
        repeat (25) step();
        div_run = 1'b1;
      end
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_serializer.md
# tick_serializer

Downstream consumer of the divided clock produced by the team's clock divider. It samples the divider's `div_clk` level in the system clock domain and turns each rising edge into a one-cycle tick. It accepts a parallel word through a valid/ready handshake and shifts the word out on `sdo`, one bit per tick. It reports frame activity and completion to the controlling logic.

## Interface
- `DATA_W`, 16: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 sends bit `DATA_W-1` first; 0 sends bit 0 first.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `div_clk`  in  1  divided clock level from the clock divider; already synchronous to `clk`.
- `din`  in  DATA_W  word to transmit; sampled on acceptance.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can accept a word; combinational, equals (state == IDLE).
- `sdo`  out  1  serial data; registered.
- `frame`  out  1  high while a bit is being driven on `sdo`; registered.
- `done`  out  1  one-cycle pulse at the end of a frame; registered.

## Operation
- Edge detect:
  - `div_q` is a register holding `div_clk` from the previous cycle.
  - `tick = div_clk & ~div_q`.
  - `div_q` resets to 1, so `div_clk` must be seen low, then high, before the first tick after reset.
- Registers: shift register (DATA_W), bit counter (width $clog2(DATA_W+1)), 2-bit state.
- IDLE:
  - `din_ready`=1, `sdo`=0, `frame`=0.
  - When `din_valid` & `din_ready`: load `din` into the shift register, clear the counter, go to WAIT.
  - A tick in the acceptance cycle is ignored.
- WAIT:
  - `din_ready`=0.
  - On a tick: drive the first bit on `sdo`, set `frame`=1, counter=1, go to SHIFT.
- SHIFT, on each tick:
  - If counter < DATA_W: drive the next bit, shift the register, increment the counter.
  - If counter == DATA_W: `sdo`=0, `frame`=0, `done`=1 for one cycle, go to IDLE.
- Bit order:
  - MSB_FIRST=1: bits are sent `din[DATA_W-1]` down to `din[0]`.
  - MSB_FIRST=0: bits are sent `din[0]` up to `din[DATA_W-1]`.
- Each bit is held on `sdo` for exactly one tick period. A frame takes DATA_W+1 ticks after acceptance (first tick to the done tick).
- `din_valid` while `din_ready`=0 is ignored. The word in flight is never modified.
- If `div_clk` stops toggling, the block holds its state indefinitely. There is no timeout.
- `din` need not stay stable after the acceptance cycle.

## Timing
- Reset values: state=IDLE, `div_q`=1, `sdo`=0, `frame`=0, `done`=0, counter=0, shift register=0. `din_ready`=1 during and after reset.
- Reset assertion mid-frame:
  - Outputs go to their reset values immediately (asynchronously).
  - No `done` pulse is produced.
  - The word in flight is discarded.
- Tick latency:
  - `div_clk` rises after clk edge E0, so `tick` is high during cycle E0–E1.
  - `sdo`, `frame` and `done` update at E1, i.e. one clk after `div_clk` rises.
- Acceptance:
  - Occurs on the clk edge where `din_valid` & `din_ready`.
  - `din_ready` falls in the next cycle.
- Back-to-back frames:
  - `done` is high in the cycle after the last tick's edge, and `din_ready` is 1 in that same cycle.
  - A new word can be accepted on that edge. Its first bit goes out on the following tick.
- The block needs ≥ 2 clk cycles between ticks; the divider guarantees this for CLK_DIV ≥ 4.

## Test plan
- DATA_W=8, MSB_FIRST=1, `div_clk` period 16 clk, `din`=8'hA5 -> `sdo` is 1,0,1,0,0,1,0,1, each bit held 16 clk. `frame` is high for 128 clk. `done` pulses once, 1 clk after the 9th tick. `sdo`=0 afterwards.
- MSB_FIRST=0, `din`=8'h01 -> `sdo` is 1 for the first tick period, then 0 for the next 7. `done` follows the 9th tick.
- `din_valid` held high with 8'hA5 then 8'h3C -> 8'h3C is accepted in the `done` cycle of the first frame. Its first bit (0) appears 1 clk after the next tick, with no gap frame.
- `din_valid` pulsed with 8'hFF during SHIFT -> ignored. The current frame completes unchanged and `din_ready` stays 0 until `done`.
- `rst` asserted after 3 ticks of a frame -> `sdo`=0, `frame`=0, `done`=0 immediately. No `done` ever pulses for that frame. `din_ready`=1.
- `rst` released while `div_clk`=1 -> no tick until `div_clk` goes low then high. The first bit of a word accepted before that edge appears 1 clk after that edge.
